// File: rtl/keypad_entry_fifo.sv
// rtl/keypad_entry_fifo.sv - keypad digit entry with hex/decimal conversion and output FIFO
//
// Purpose: turns debounced keypad coordinates into DATA_WIDTH-bit words. Digits
// are collected in a nibble buffer with shift/backspace/clear editing. A confirm
// pushes the word into a small FIFO. Hex entries are pushed directly. Decimal
// entries are converted one digit per cycle.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   key_coord       {row_onehot, col_onehot}, 8'h00 = no key
//   input_enable    0 ignores keystrokes and clears the pending shift
//   dec_mode        radix for a new entry (1 = decimal), latched on first digit
//   out_ready       CPU accepts FIFO head
//   out_data        FIFO head value
//   out_overflow    FIFO head decimal-overflow flag
//   out_valid       FIFO not empty
//   fifo_full       FIFO holds FIFO_DEPTH entries
//   entry_digits    entry buffer, nibble 0 = most recent digit
//   digit_count     digits currently in the entry
//   entry_mode      latched radix of the current entry
//   shift_active    shift modifier pending
//   busy            decimal conversion in progress
module keypad_entry_fifo #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEC_DIGITS = 10,
  parameter  int FIFO_DEPTH = 4,
  localparam int HEX_DIGITS = DATA_WIDTH / 4,
  localparam int BUF_DIGITS = (HEX_DIGITS > DEC_DIGITS) ? HEX_DIGITS : DEC_DIGITS,
  localparam int CW         = $clog2(BUF_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              key_coord,
  input  logic                    input_enable,
  input  logic                    dec_mode,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_overflow,
  output logic                    out_valid,
  output logic                    fifo_full,
  output logic [4*BUF_DIGITS-1:0] entry_digits,
  output logic [CW-1:0]           digit_count,
  output logic                    entry_mode,
  output logic                    shift_active,
  output logic                    busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = 4 * BUF_DIGITS;
  localparam int AW = DATA_WIDTH + 4;
  localparam logic [CW-1:0] HEX_LIM  = CW'(HEX_DIGITS);
  localparam logic [CW-1:0] DEC_LIM  = CW'(DEC_DIGITS);
  localparam logic [PW:0]   FIFO_LIM = (PW + 1)'(FIFO_DEPTH);

  // Internal key codes: 0-9 digits, A-D letters, E = '*', F = '#'.
  localparam logic [3:0] K_A    = 4'hA;
  localparam logic [3:0] K_B    = 4'hB;
  localparam logic [3:0] K_C    = 4'hC;
  localparam logic [3:0] K_D    = 4'hD;
  localparam logic [3:0] K_STAR = 4'hE;
  localparam logic [3:0] K_HASH = 4'hF;

  // Indexed by {row, col}.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, K_A,
    4'h4, 4'h5, 4'h6, K_B,
    4'h7, 4'h8, 4'h9, K_C,
    K_STAR, 4'h0, K_HASH, K_D
  };

  typedef enum logic {ENTRY = 1'b0, CONVERT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [7:0]            key_cur, key_prev;
  logic [BW-1:0]         buf_q, buf_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic                  shift_q, shift_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  logic [CW-1:0]         idx_q, idx_d;

  logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           fifo_cnt;

  logic                  key_valid, key_event;
  logic [1:0]            row_idx, col_idx;
  logic [3:0]            key_val;
  logic                  eff_dec;
  logic                  do_digit;
  logic [3:0]            digit_val;
  logic [3:0]            conv_nib;
  logic [AW-1:0]         conv_wide;
  logic                  push, pop;
  logic [DATA_WIDTH:0]   push_word;

  // ---------------------------------------------------------------- key decode
  always_comb begin
    row_idx = 2'd0;
    col_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (key_cur[4+i]) row_idx = 2'(i);
      if (key_cur[i])   col_idx = 2'(i);
    end
  end

  assign key_valid = $onehot(key_cur[7:4]) && $onehot(key_cur[3:0]);
  // Only a clean 00 -> valid transition counts, so a held key fires once.
  assign key_event = key_valid && (key_prev == 8'h00);
  assign key_val   = KEY_MAP[{row_idx, col_idx}];

  // Radix that governs the next digit: a fresh entry follows dec_mode,
  // a started entry keeps its latched radix.
  assign eff_dec = (cnt_q == '0) ? dec_mode : mode_q;

  // Decimal conversion step, exact in DATA_WIDTH+4 bits.
  assign conv_nib  = buf_q[idx_q*4 +: 4];
  assign conv_wide = ({4'b0000, acc_q} * AW'(10)) + AW'(conv_nib);

  // ------------------------------------------------------- next-state / edits
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    idx_d     = idx_q;
    do_digit  = 1'b0;
    digit_val = 4'h0;
    push      = 1'b0;
    push_word = '0;

    case (state_q)
      ENTRY: begin
        if (key_event && input_enable) begin
          if (shift_q) begin
            shift_d = 1'b0;
            case (key_val)
              K_A: if (!eff_dec) begin do_digit = 1'b1; digit_val = 4'hE; end
              K_B: if (!eff_dec) begin do_digit = 1'b1; digit_val = 4'hF; end
              K_C: if (cnt_q != '0) begin
                buf_d = buf_q >> 4;
                cnt_d = cnt_q - 1'b1;
              end
              default: ;
            endcase
          end else begin
            case (key_val)
              K_A, K_B, K_C: if (!eff_dec) begin do_digit = 1'b1; digit_val = key_val; end
              K_D: shift_d = 1'b1;
              K_STAR: begin
                buf_d = '0;
                cnt_d = '0;
              end
              K_HASH: if ((cnt_q != '0) && !fifo_full) begin
                if (mode_q) begin
                  state_d = CONVERT;
                  acc_d   = '0;
                  ovf_d   = 1'b0;
                  idx_d   = cnt_q - 1'b1;
                end else begin
                  push      = 1'b1;
                  push_word = {1'b0, buf_q[DATA_WIDTH-1:0]};
                  buf_d     = '0;
                  cnt_d     = '0;
                end
              end
              default: begin
                do_digit  = 1'b1;
                digit_val = key_val;
              end
            endcase
          end

          if (do_digit && (cnt_q < (eff_dec ? DEC_LIM : HEX_LIM))) begin
            buf_d = {buf_q[BW-5:0], digit_val};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '0) mode_d = dec_mode;
          end
        end
      end

      CONVERT: begin
        acc_d = conv_wide[DATA_WIDTH-1:0];
        ovf_d = ovf_q | (|conv_wide[AW-1:DATA_WIDTH]);
        if (idx_q == '0) begin
          // Entry to CONVERT required a non-full FIFO and only pops happen
          // meanwhile, so this push always has room.
          push      = 1'b1;
          push_word = {ovf_d, acc_d};
          buf_d     = '0;
          cnt_d     = '0;
          state_d   = ENTRY;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      default: state_d = ENTRY;
    endcase

    if (!input_enable) shift_d = 1'b0;
  end

  // ------------------------------------------------------------ state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ENTRY;
      key_cur  <= '0;
      key_prev <= '0;
      buf_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      shift_q  <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      key_cur  <= key_coord;
      key_prev <= key_cur;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      idx_q    <= idx_d;
    end
  end

  // ---------------------------------------------------------------- output FIFO
  assign out_valid = (fifo_cnt != '0);
  assign fifo_full = (fifo_cnt == FIFO_LIM);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_word;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign out_data     = fifo_mem[rd_ptr][DATA_WIDTH-1:0];
  assign out_overflow = fifo_mem[rd_ptr][DATA_WIDTH];

  assign entry_digits = buf_q;
  assign digit_count  = cnt_q;
  assign entry_mode   = mode_q;
  assign shift_active = shift_q;
  assign busy         = (state_q == CONVERT);

endmodule

// File: tb/tb_keypad_entry_fifo.sv
// tb/tb_keypad_entry_fifo.sv - self-checking bench for keypad_entry_fifo
module tb_keypad_entry_fifo;

  localparam int DW = 32;
  localparam int BD = 10;
  localparam int CW = $clog2(BD + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    key_coord = 8'h00;
  logic          input_enable = 1'b1;
  logic          dec_mode = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_overflow;
  logic          out_valid;
  logic          fifo_full;
  logic [4*BD-1:0] entry_digits;
  logic [CW-1:0] digit_count;
  logic          entry_mode;
  logic          shift_active;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q [$];

  keypad_entry_fifo dut (
    .clk(clk), .rst_n(rst_n), .key_coord(key_coord), .input_enable(input_enable),
    .dec_mode(dec_mode), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_overflow), .out_valid(out_valid), .fifo_full(fifo_full),
    .entry_digits(entry_digits), .digit_count(digit_count), .entry_mode(entry_mode),
    .shift_active(shift_active), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       keys;
    bit          dec;
    logic [31:0] exp_data;
    bit          exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] key_code(input byte c);
    int r, k;
    case (c)
      "1": begin r = 0; k = 0; end
      "2": begin r = 0; k = 1; end
      "3": begin r = 0; k = 2; end
      "A": begin r = 0; k = 3; end
      "4": begin r = 1; k = 0; end
      "5": begin r = 1; k = 1; end
      "6": begin r = 1; k = 2; end
      "B": begin r = 1; k = 3; end
      "7": begin r = 2; k = 0; end
      "8": begin r = 2; k = 1; end
      "9": begin r = 2; k = 2; end
      "C": begin r = 2; k = 3; end
      "*": begin r = 3; k = 0; end
      "0": begin r = 3; k = 1; end
      "#": begin r = 3; k = 2; end
      default: begin r = 3; k = 3; end
    endcase
    return {4'(1 << r), 4'(1 << k)};
  endfunction

  task automatic press(input byte c);
    key_coord = key_code(c);
    cyc(2);
    key_coord = 8'h00;
    cyc(2);
  endtask

  task automatic type_keys(input string s, input logic [DW:0] exp);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "#") exp_q.push_back(exp);
      press(s[i]);
    end
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (!busy && !out_valid && exp_q.size() == 0) done = 1'b1;
      else cyc(1);
    end
    check(name, {63'd0, done}, 64'd1);
  endtask

  // Scoreboard: every accepted pop is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got %0h expected no output", out_data);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        check("pop_data", 64'(out_data), 64'(e[DW-1:0]));
        check("pop_ovf", 64'(out_overflow), 64'(e[DW]));
      end
    end
  end

  vec_t vecs [10];

  initial begin
    int bcnt;

    vecs[0] = '{"12DA#",        1'b0, 32'h0000012E, 1'b0};
    vecs[1] = '{"123DC#",       1'b0, 32'h00000012, 1'b0};
    vecs[2] = '{"4294967295#",  1'b1, 32'hFFFFFFFF, 1'b0};
    vecs[3] = '{"4294967296#",  1'b1, 32'h00000000, 1'b1};
    vecs[4] = '{"12345678901#", 1'b1, 32'h499602D2, 1'b0};
    vecs[5] = '{"123456789#",   1'b0, 32'h12345678, 1'b0};
    vecs[6] = '{"5*7#",         1'b0, 32'h00000007, 1'b0};
    vecs[7] = '{"DDB#",         1'b0, 32'h0000000B, 1'b0};
    vecs[8] = '{"D5DB#",        1'b0, 32'h0000000F, 1'b0};
    vecs[9] = '{"1A2#",         1'b1, 32'h0000000C, 1'b0};

    cyc(3);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fifo_full", 64'(fifo_full), 64'd0);
    check("rst_count", 64'(digit_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_digits", 64'(entry_digits), 64'd0);
    check("rst_shift", 64'(shift_active), 64'd0);
    rst_n = 1'b1;
    cyc(1);

    for (int v = 0; v < 10; v++) begin
      dec_mode = vecs[v].dec;
      type_keys(vecs[v].keys, {vecs[v].exp_ovf, vecs[v].exp_data});
      wait_idle("vec_drain");
      check("vec_count_cleared", 64'(digit_count), 64'd0);
    end

    // Confirm with an empty entry pushes nothing.
    dec_mode = 1'b0;
    press("#");
    cyc(3);
    check("empty_confirm", 64'(out_valid), 64'd0);

    // Shift modifier toggling.
    press("D");
    check("shift_set", 64'(shift_active), 64'd1);
    press("D");
    check("shift_cancel", 64'(shift_active), 64'd0);

    // Decimal busy window is one cycle per digit.
    dec_mode = 1'b1;
    type_keys("4294967295", '0);
    exp_q.push_back({1'b0, 32'hFFFFFFFF});
    key_coord = key_code("#");
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (i == 1) key_coord = 8'h00;
      if (busy) bcnt++;
    end
    check("busy_cycles", 64'(bcnt), 64'd10);
    wait_idle("busy_drain");

    // Held key fires once.
    dec_mode = 1'b0;
    key_coord = key_code("7");
    cyc(50);
    key_coord = 8'h00;
    cyc(2);
    press("7");
    check("held_count", 64'(digit_count), 64'd2);
    check("held_digits", 64'(entry_digits[7:0]), 64'h77);
    press("*");
    check("clear_count", 64'(digit_count), 64'd0);

    // FIFO fill with CPU stalled, fifth entry retained.
    out_ready = 1'b0;
    begin
      string s = "12345";
      for (int k = 0; k < 5; k++) begin
        if (k < 4) exp_q.push_back({1'b0, 32'(k + 1)});
        press(s[k]);
        press("#");
      end
    end
    check("fifo_full", 64'(fifo_full), 64'd1);
    check("retained_count", 64'(digit_count), 64'd1);
    check("retained_digit", 64'(entry_digits[3:0]), 64'd5);
    check("head_before_drain", 64'(out_data), 64'd1);
    out_ready = 1'b1;
    cyc(4);
    check("drained_in_4", 64'(out_valid), 64'd0);
    check("drain_queue", 64'(exp_q.size()), 64'd0);
    press("*");

    // Reset mid-conversion discards it.
    dec_mode = 1'b1;
    type_keys("999", '0);
    key_coord = key_code("#");
    cyc(2);
    check("mid_convert_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    key_coord = 8'h00;
    cyc(1);
    check("rst_conv_busy", 64'(busy), 64'd0);
    check("rst_conv_valid", 64'(out_valid), 64'd0);
    check("rst_conv_count", 64'(digit_count), 64'd0);
    rst_n = 1'b1;
    cyc(15);
    check("no_output_after_rst", 64'(out_valid), 64'd0);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/keypad_entry_fifo.md
# keypad_entry_fifo

Parametrised keypad entry unit that turns debounced keypad coordinates into DATA_WIDTH-bit words in hex or decimal, with shift, backspace and clear editing. Confirmed words go into an output FIFO drained by the CPU over a valid/ready handshake. It sits between the keypad scanner and the CPU input path and exposes the live entry buffer to the seven-segment driver. It extends the single-word input unit with configurable width, decimal mode and multi-entry buffering.

## Interface
- DATA_WIDTH, 32, output word width; multiple of 4, 8..64.
- DEC_DIGITS, 10, maximum decimal digits per entry.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.
- BUF_DIGITS (localparam) = max(DATA_WIDTH/4, DEC_DIGITS); HEX_DIGITS (localparam) = DATA_WIDTH/4.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- key_coord  in  8  {row_onehot[3:0], col_onehot[3:0]}; 8'h00 means no key.
- input_enable  in  1  when 0, keystrokes are ignored and the shift flag is cleared.
- dec_mode  in  1  entry radix: 1 = decimal, 0 = hex. Latched on the first accepted digit of each entry.
- out_ready  in  1  CPU accepts the FIFO head.
- out_data  out  DATA_WIDTH  FIFO head value.
- out_overflow  out  1  FIFO head flag: decimal value exceeded 2^DATA_WIDTH−1.
- out_valid  out  1  FIFO not empty.
- fifo_full  out  1  FIFO count == FIFO_DEPTH.
- entry_digits  out  4*BUF_DIGITS  entry buffer as nibbles; nibble 0 is the last digit entered.
- digit_count  out  $clog2(BUF_DIGITS+1)  number of digits in the entry.
- entry_mode  out  1  latched radix of the current entry.
- shift_active  out  1  shift modifier is pending.
- busy  out  1  state is CONVERT.

## Operation
- Keypad layout by row0..3 / col0..3: "1 2 3 A", "4 5 6 B", "7 8 9 C", "* 0 # D".
- Valid code: exactly one bit set in each nibble. Any other nonzero code is ignored and does not arm edge detection.
- Keystroke event: key_coord is registered. An event fires when the registered previous value is 00 and the registered current value is valid. A held key gives one event.
- Events are ignored when input_enable = 0 or state = CONVERT.
- Unshifted keys:
  - 0–9: digit.
  - A, B, C: hex digits; ignored in decimal mode.
  - D: sets shift.
  - `*`: clear entry.
  - `#`: confirm.
- Shifted keys (shift_active = 1). Every shifted keystroke clears shift.
  - A → digit E; B → digit F. Both ignored in decimal mode.
  - C → backspace: nibbles shift right by one, count−1; no-op when count = 0.
  - D → cancel shift.
  - Any other key: ignored.
- Digit accept rule: count < HEX_DIGITS in hex, count < DEC_DIGITS in decimal. Extra digits are dropped.
- Accepting a digit: buffer shifts left one nibble, the new digit enters nibble 0, count+1.
- When count = 0, dec_mode is copied to entry_mode on the accepted digit.
- Confirm is ignored when count = 0 or fifo_full = 1; the entry is retained.
- State machine with states ENTRY and CONVERT; reset state is ENTRY.
  - Hex confirm: pushes {overflow = 0, value = nibble concatenation, zero-extended}, clears the entry, stays in ENTRY.
  - Decimal confirm: goes to CONVERT with acc = 0 and index = count−1.
  - CONVERT: each cycle, acc = acc*10 + nibble[index]. The computation is exact in DATA_WIDTH+4 bits, and the sticky overflow flag sets if the upper bits are nonzero. acc is truncated to DATA_WIDTH.
  - After the nibble[0] cycle: push {overflow, acc}, clear the entry, return to ENTRY.
- FIFO:
  - Pop when out_valid & out_ready.
  - Full is judged on the current count; a same-cycle pop does not make room for a confirm.
  - Push and pop in the same cycle are both performed when the FIFO is neither full (push) nor empty (pop).
  - Pointers wrap modulo FIFO_DEPTH.
- Reset: all registers and outputs are 0, state is ENTRY, the FIFO is empty. A reset during CONVERT discards the conversion.

## Timing
- key_coord becomes valid at cycle 0. The event is asserted in cycle 1. Buffer, count and shift changes are visible in cycle 2.
- Hex `#` first valid at cycle 0: out_valid is visible in cycle 2 if the FIFO was empty.
- Decimal `#` with n digits: busy is 1 during cycles 2..n+1; out_valid is visible in cycle n+2.
- out_data and out_overflow are the FIFO head, driven combinationally from FIFO storage.
- Pop is visible one cycle after the out_valid & out_ready edge.
- Throughput: one pop per cycle.

## Test plan
- Hex mode, keys 1,2,D,A,#, each released between presses → out_data = 32'h0000012E, out_overflow = 0, digit_count returns to 0.
- Hex mode, keys 1,2,3,D,C,# → 32'h00000012. With count = 0, `#` → no push.
- Decimal, 4294967295 then # → out_data = 32'hFFFFFFFF, overflow = 0, busy for 10 cycles. Decimal 4294967296 then # → out_data = 0, overflow = 1. An 11th digit is dropped.
- Key 7 held for 50 cycles, then released, then 7 again → count = 2, entry_digits[7:0] = 8'h77.
- out_ready = 0, five confirmed hex entries 1..5 → fifo_full = 1 after four, entry "5" retained. Raise out_ready → values 1,2,3,4 pop one per cycle.
- Assert rst_n = 0 for one cycle mid-CONVERT → busy = 0, out_valid = 0, digit_count = 0 on the next cycle.
